// File: rtl/lut4_pkg.sv
// ---------------------------------------------------------------------------
// lut4_pkg
// Shared definitions for the LUT4 / S-box sequencer:
//   - FSM state encoding (IDLE, LO, HI, RESP)
//   - operation codes (LUT4 single pass, SBOX4 two passes)
//   - helper that merges the low-bit and high-bit pass results per nibble
// No ports (package).
// ---------------------------------------------------------------------------
package lut4_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LO   = 2'd1;
    localparam state_t ST_HI   = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    localparam logic OP_LUT4  = 1'b0;
    localparam logic OP_SBOX4 = 1'b1;

    // Each pass yields {2'b00, entry} per nibble; the S-box result takes the
    // two live bits of each pass and stacks hi over lo.
    function automatic logic [31:0] sbox_merge(input logic [31:0] res_lo,
                                               input logic [31:0] res_hi);
        logic [31:0] merged;
        merged = 32'd0;
        for (int i = 0; i < 8; i++) begin
            merged[4*i +: 4] = {res_hi[4*i +: 2], res_lo[4*i +: 2]};
        end
        return merged;
    endfunction

endpackage

// File: rtl/lut4_rv32_v1.sv
// ---------------------------------------------------------------------------
// lut4_rv32_v1
// Combinational 2-bit LUT4 lookup over eight nibbles.
//   rs1_i [31:0] : eight 4-bit indices
//   rs2_i [31:0] : sixteen 2-bit table entries, entry k at bits [2k+1:2k]
//   rd_o  [31:0] : nibble i = {2'b00, entry[rs1_i nibble i]}
// ---------------------------------------------------------------------------
module lut4_rv32_v1 (
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] rd_o
);

    function automatic logic [1:0] pick(input logic [31:0] tab,
                                        input logic [3:0]  k);
        return tab[{k, 1'b0} +: 2];
    endfunction

    // Eight independent table lookups, one per nibble.
    always_comb begin
        rd_o = 32'd0;
        for (int i = 0; i < 8; i++) begin
            rd_o[4*i +: 4] = {2'b00, pick(rs2_i, rs1_i[4*i +: 4])};
        end
    end

endmodule

// File: rtl/lut4_sbox_seq.sv
// ---------------------------------------------------------------------------
// lut4_sbox_seq
// Sequencer time-sharing one lut4_rv32_v1 datapath to perform either a LUT4
// lookup (one pass) or a 4-bit S-box (low-bit pass then high-bit pass).
//   clk, resetn            : clock (rising edge), async active-low reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_op                 : 0 = LUT4, 1 = SBOX4
//   req_rs1                : eight 4-bit indices
//   req_lut_lo/req_lut_hi  : 2-bit tables for result bits [1:0] / [3:2]
//   rsp_valid/rsp_ready    : response handshake (valid only in RESP)
//   rsp_rd                 : result, driven from registers only
//   busy                   : any state other than IDLE
//   op_count [COUNT_W-1:0] : responses handed off since reset (wraps)
// ---------------------------------------------------------------------------
module lut4_sbox_seq
    import lut4_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [31:0]        req_rs1,
    input  logic [31:0]        req_lut_lo,
    input  logic [31:0]        req_lut_hi,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rd,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    state_t              state_q, state_d;
    logic                op_q;
    logic [31:0]         rs1_q, lut_lo_q, lut_hi_q;
    logic [31:0]         res_lo_q, res_hi_q;
    logic [COUNT_W-1:0]  op_count_q;
    logic [31:0]         dp_rs2_s, dp_rd_s;
    logic                accept_s, handoff_s;

    assign accept_s  = (state_q == ST_IDLE) & req_valid;
    assign handoff_s = (state_q == ST_RESP) & rsp_ready;

    // Select which latched table feeds the shared datapath this cycle.
    always_comb begin
        if (state_q == ST_HI) begin
            dp_rs2_s = lut_hi_q;
        end else begin
            dp_rs2_s = lut_lo_q;
        end
    end

    lut4_rv32_v1 u_dp (
        .rs1_i (rs1_q),
        .rs2_i (dp_rs2_s),
        .rd_o  (dp_rd_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = ST_LO;
                else           state_d = ST_IDLE;
            end
            ST_LO: begin
                if (op_q == OP_SBOX4) state_d = ST_HI;
                else                  state_d = ST_RESP;
            end
            ST_HI:   state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
                else           state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded straight from the state register.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    // Operand capture on accept; held for the whole operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= OP_LUT4;
            rs1_q    <= 32'd0;
            lut_lo_q <= 32'd0;
            lut_hi_q <= 32'd0;
        end else if (accept_s) begin
            op_q     <= req_op;
            rs1_q    <= req_rs1;
            lut_lo_q <= req_lut_lo;
            lut_hi_q <= req_lut_hi;
        end else begin
            op_q     <= op_q;
            rs1_q    <= rs1_q;
            lut_lo_q <= lut_lo_q;
            lut_hi_q <= lut_hi_q;
        end
    end

    // Pass results: LO state fills res_lo, HI state fills res_hi.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
        end else if (state_q == ST_LO) begin
            res_lo_q <= dp_rd_s;
        end else if (state_q == ST_HI) begin
            res_hi_q <= dp_rd_s;
        end else begin
            res_lo_q <= res_lo_q;
            res_hi_q <= res_hi_q;
        end
    end

    // Response word built from the result registers only, so it stays stable
    // throughout RESP and never sees the request inputs.
    always_comb begin
        if (op_q == OP_SBOX4) begin
            rsp_rd = sbox_merge(res_lo_q, res_hi_q);
        end else begin
            rsp_rd = res_lo_q;
        end
    end

    // Completed-response counter, wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_count_q <= '0;
        end else if (handoff_s) begin
            op_count_q <= op_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            op_count_q <= op_count_q;
        end
    end

    assign op_count = op_count_q;

endmodule

// File: tb/tb_lut4_sbox_seq.sv
module tb_lut4_sbox_seq;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_valid, req_ready, req_op;
    logic [31:0]   req_rs1, req_lut_lo, req_lut_hi;
    logic          rsp_valid, rsp_ready, busy;
    logic [31:0]   rsp_rd;
    logic [CW-1:0] op_count;

    logic rdy_mode  = 1'b0;
    logic rdy_force = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lut4_sbox_seq #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_lut_lo (req_lut_lo),
        .req_lut_hi (req_lut_hi),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rd     (rsp_rd),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per-nibble table lookups with plain integer arithmetic.
    function automatic logic [31:0] ref_calc(input logic op, input logic [31:0] rs1,
                                             input logic [31:0] lo, input logic [31:0] hi);
        int unsigned r, idx, lv, hv, nib;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            idx = (rs1 >> (4 * i)) & 15;
            lv  = (lo >> (2 * idx)) & 3;
            hv  = (hi >> (2 * idx)) & 3;
            nib = op ? (hv * 4 + lv) : lv;
            r   = r | (nib << (4 * i));
        end
        return r;
    endfunction

    // Transaction-level model: one op in flight, result appears after 2/3 edges.
    logic          m_inflight, m_valid;
    int            m_wait;
    logic [31:0]   m_res;
    logic [CW-1:0] m_count;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_inflight <= 1'b0;
            m_valid    <= 1'b0;
            m_wait     <= 0;
            m_res      <= 32'd0;
            m_count    <= '0;
        end else if (m_valid) begin
            if (rsp_ready) begin
                m_valid    <= 1'b0;
                m_inflight <= 1'b0;
                m_count    <= m_count + {{(CW-1){1'b0}}, 1'b1};
            end
        end else if (m_inflight) begin
            if (m_wait == 1) m_valid <= 1'b1;
            m_wait <= m_wait - 1;
        end else if (req_valid) begin
            m_res      <= ref_calc(req_op, req_rs1, req_lut_lo, req_lut_hi);
            m_inflight <= 1'b1;
            m_wait     <= req_op ? 2 : 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("req_ready", {31'd0, req_ready}, {31'd0, ~m_inflight});
        check("busy",      {31'd0, busy},      {31'd0, m_inflight});
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        check("op_count",  {30'd0, op_count},  {30'd0, m_count});
        if (m_valid) check("rsp_rd", rsp_rd, m_res);
    end

    // Response-side ready: forced level or random.
    always @(negedge clk) begin
        #1;
        rsp_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic issue(input logic op, input logic [31:0] rs1,
                         input logic [31:0] lo, input logic [31:0] hi);
        logic acc;
        req_op = op; req_rs1 = rs1; req_lut_lo = lo; req_lut_hi = hi;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 100; k++) begin
            acc = req_ready;
            @(negedge clk);
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        req_valid  = 1'b0;
        req_op     = 1'($urandom_range(0, 1));
        req_rs1    = $urandom;
        req_lut_lo = $urandom;
        req_lut_hi = $urandom;
    endtask

    task automatic send(input logic op, input logic [31:0] rs1, input logic [31:0] lo,
                        input logic [31:0] hi, output int lat);
        issue(op, rs1, lo, hi);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (!m_inflight) break;
            @(negedge clk);
        end
        if (m_inflight) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] saved, r1, l1, h1, expv;

        resetn = 1'b0;
        req_valid = 1'b1; req_op = 1'b1;
        req_rs1 = $urandom; req_lut_lo = $urandom; req_lut_hi = $urandom;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rd",    rsp_rd,             32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_op_count",  {30'd0, op_count},  32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // LUT4 directed
        send(1'b0, 32'h7654_3210, 32'hE4E4_E4E4, $urandom, lat);
        check("lut4_latency", lat, 32'd2);
        check("lut4_result",  rsp_rd, 32'h3210_3210);
        @(negedge clk);
        check("lut4_count",   {30'd0, op_count}, 32'd1);

        // SBOX4 identity
        send(1'b1, 32'hFEDC_BA98, 32'hE4E4_E4E4, 32'hFFAA_5500, lat);
        check("sbox_latency", lat, 32'd3);
        check("sbox_result",  rsp_rd, 32'hFEDC_BA98);
        @(negedge clk);

        // Backpressure with a second request waiting
        rdy_force = 1'b0;
        send(1'b0, $urandom, $urandom, $urandom, lat);
        saved = rsp_rd;
        req_op = 1'b1; req_rs1 = $urandom; req_lut_lo = $urandom; req_lut_hi = $urandom;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",  {31'd0, rsp_valid}, 32'd1);
            check("bp_ready",  {31'd0, req_ready}, 32'd0);
            check("bp_stable", rsp_rd, saved);
        end
        rdy_force = 1'b1;
        send(req_op, req_rs1, req_lut_lo, req_lut_hi, lat);
        wait_idle();

        // Operand latching: inputs scrambled right after accept
        r1 = $urandom; l1 = $urandom; h1 = $urandom;
        expv = ref_calc(1'b1, r1, l1, h1);
        send(1'b1, r1, l1, h1, lat);
        check("latch_result", rsp_rd, expv);
        wait_idle();

        // Reset during HI
        issue(1'b1, $urandom, $urandom, $urandom);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        req_valid = 1'b1;
        #1;
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_busy",      {31'd0, busy},      32'd0);
        check("mid_rst_op_count",  {30'd0, op_count},  32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        r1 = $urandom; l1 = $urandom; h1 = $urandom;
        expv = ref_calc(1'b1, r1, l1, h1);
        send(1'b1, r1, l1, h1, lat);
        check("post_rst_result", rsp_rd, expv);
        wait_idle();

        // Random traffic with random backpressure
        rdy_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        rdy_mode = 1'b0;
        rdy_force = 1'b1;

        // Counter wrap: five SBOX4 ops from reset on a 2-bit counter
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            send(1'b1, $urandom, $urandom, $urandom, lat);
        end
        wait_idle();
        check("wrap_count", {30'd0, op_count}, 32'd1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
